wave_dispatcher: RTL and testbench

//  Kernel-level wave scheduler in front of the SIMD units. On a kernel launch it hands wave IDs
//  0..num_waves-1 to idle SIMD units, one per cycle, with round-robin arbitration.

---
 rtl/wave_dispatcher.sv | 176 +++++++++++++++++
 tb/tb_wave_dispatcher.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_dispatcher.sv
// Kernel wave dispatcher: hands wave IDs to idle SIMD units round-robin and reports kernel completion.
// Optional cycle counter output kernel_cycles is enabled by defining WAVE_DISPATCH_PERF_EN.
module wave_dispatcher #(
    parameter int NUM_SIMD      = 4,
    parameter int WAVE_ID_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     launch,
    input  logic [WAVE_ID_WIDTH-1:0] num_waves,
    input  logic [NUM_SIMD-1:0]      simd_wave_done,
    output logic [NUM_SIMD-1:0]      simd_dispatch,
    output logic [WAVE_ID_WIDTH-1:0] dispatch_wave_id,
    output logic                     busy,
    output logic                     kernel_done
`ifdef WAVE_DISPATCH_PERF_EN
    ,
    output logic [31:0]              kernel_cycles
`endif
);

    localparam int PTR_W = $clog2(NUM_SIMD);
    localparam logic [PTR_W:0]   SIMD_CNT = (PTR_W+1)'(NUM_SIMD);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_SIMD - 1);

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

    state_t                   state_reg, state_next;
    logic [WAVE_ID_WIDTH-1:0] total_reg, total_next;
    logic [WAVE_ID_WIDTH-1:0] next_wave_reg, next_wave_next;
    logic [WAVE_ID_WIDTH-1:0] done_cnt_reg, done_cnt_next;
    logic [NUM_SIMD-1:0]      occupancy_reg, occupancy_next;
    logic [PTR_W-1:0]         rr_ptr_reg, rr_ptr_next;
    logic [NUM_SIMD-1:0]      simd_dispatch_reg, simd_dispatch_next;
    logic [WAVE_ID_WIDTH-1:0] dispatch_wave_id_reg, dispatch_wave_id_next;
    logic                     busy_reg, busy_next;
    logic                     kernel_done_reg, kernel_done_next;

    logic [PTR_W:0]           cand_sum [NUM_SIMD];
    logic [PTR_W-1:0]         cand_idx [NUM_SIMD];
    logic                     grant_found;
    logic [PTR_W-1:0]         grant_idx;
    logic [NUM_SIMD-1:0]      done_hits;
    logic [WAVE_ID_WIDTH-1:0] done_inc;

    // Candidate unit for each search offset, wrapped circularly from rr_ptr.
    generate
        for (genvar gi = 0; gi < NUM_SIMD; gi++) begin : g_cand
            assign cand_sum[gi] = {1'b0, rr_ptr_reg} + (PTR_W+1)'(gi);
            assign cand_idx[gi] = (cand_sum[gi] >= SIMD_CNT) ? PTR_W'(cand_sum[gi] - SIMD_CNT)
                                                             : cand_sum[gi][PTR_W-1:0];
        end
    endgenerate

    // Arbitration looks only at registered occupancy, so a same-cycle free is not seen.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_SIMD; k++) begin
            if (!grant_found && !occupancy_reg[cand_idx[k]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    assign done_hits = simd_wave_done & occupancy_reg;

    always_comb begin
        done_inc = '0;
        for (int k = 0; k < NUM_SIMD; k++) begin
            done_inc = done_inc + WAVE_ID_WIDTH'(done_hits[k]);
        end
    end

    always_comb begin
        state_next            = state_reg;
        total_next            = total_reg;
        next_wave_next        = next_wave_reg;
        done_cnt_next         = done_cnt_reg;
        occupancy_next        = occupancy_reg;
        rr_ptr_next           = rr_ptr_reg;
        simd_dispatch_next    = '0;
        dispatch_wave_id_next = dispatch_wave_id_reg;

        // Completions only count while a kernel has waves in flight.
        if (state_reg == DISPATCH || state_reg == DRAIN) begin
            occupancy_next = occupancy_reg & ~done_hits;
            done_cnt_next  = done_cnt_reg + done_inc;
        end

        case (state_reg)
            IDLE: begin
                if (launch) begin
                    total_next     = num_waves;
                    next_wave_next = '0;
                    done_cnt_next  = '0;
                    state_next     = (num_waves != '0) ? DISPATCH : DONE;
                end
            end
            DISPATCH: begin
                if (grant_found && next_wave_reg < total_reg) begin
                    simd_dispatch_next    = NUM_SIMD'(1) << grant_idx;
                    dispatch_wave_id_next = next_wave_reg;
                    occupancy_next        = occupancy_next | (NUM_SIMD'(1) << grant_idx);
                    next_wave_next        = next_wave_reg + WAVE_ID_WIDTH'(1);
                    rr_ptr_next           = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
                    if (next_wave_next == total_reg) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (done_cnt_reg == total_reg) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        busy_next        = (state_next != IDLE);
        kernel_done_next = (state_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg            <= IDLE;
            total_reg            <= '0;
            next_wave_reg        <= '0;
            done_cnt_reg         <= '0;
            occupancy_reg        <= '0;
            rr_ptr_reg           <= '0;
            simd_dispatch_reg    <= '0;
            dispatch_wave_id_reg <= '0;
            busy_reg             <= 1'b0;
            kernel_done_reg      <= 1'b0;
        end else begin
            state_reg            <= state_next;
            total_reg            <= total_next;
            next_wave_reg        <= next_wave_next;
            done_cnt_reg         <= done_cnt_next;
            occupancy_reg        <= occupancy_next;
            rr_ptr_reg           <= rr_ptr_next;
            simd_dispatch_reg    <= simd_dispatch_next;
            dispatch_wave_id_reg <= dispatch_wave_id_next;
            busy_reg             <= busy_next;
            kernel_done_reg      <= kernel_done_next;
        end
    end

    assign simd_dispatch    = simd_dispatch_reg;
    assign dispatch_wave_id = dispatch_wave_id_reg;
    assign busy             = busy_reg;
    assign kernel_done      = kernel_done_reg;

`ifdef WAVE_DISPATCH_PERF_EN
    logic [31:0] kernel_cycles_reg;

    // Counts cycles spent outside IDLE; saturates and holds until the next accepted launch.
    always_ff @(posedge clk) begin
        if (rst) begin
            kernel_cycles_reg <= '0;
        end else if (state_reg == IDLE && launch) begin
            kernel_cycles_reg <= '0;
        end else if (state_reg != IDLE && kernel_cycles_reg != '1) begin
            kernel_cycles_reg <= kernel_cycles_reg + 32'd1;
        end
    end

    assign kernel_cycles = kernel_cycles_reg;
`endif

endmodule

// File: tb/tb_wave_dispatcher.sv
// Scoreboard bench for wave_dispatcher: directed kernels with hand-derived dispatch schedules.
module tb_wave_dispatcher;

    logic       clk = 1'b0;
    logic       rst;
    logic       launch;
    logic [7:0] num_waves;
    logic [3:0] simd_wave_done;
    logic [3:0] simd_dispatch;
    logic [7:0] dispatch_wave_id;
    logic       busy;
    logic       kernel_done;
`ifdef WAVE_DISPATCH_PERF_EN
    logic [31:0] kernel_cycles;
`endif

    wave_dispatcher #(.NUM_SIMD(4), .WAVE_ID_WIDTH(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .launch           (launch),
        .num_waves        (num_waves),
        .simd_wave_done   (simd_wave_done),
        .simd_dispatch    (simd_dispatch),
        .dispatch_wave_id (dispatch_wave_id),
        .busy             (busy),
        .kernel_done      (kernel_done)
`ifdef WAVE_DISPATCH_PERF_EN
        ,
        .kernel_cycles    (kernel_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] mask;
        logic [7:0] id;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   kd_count = 0;
    int   kd_cyc   = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every dispatch pulse is matched against the oldest expected grant.
    always @(negedge clk) begin
        if (kernel_done === 1'b1) begin
            kd_count++;
            kd_cyc = cyc;
            $display("kernel_done at cycle %0d", cyc);
        end
        if (simd_dispatch !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_dispatch: got unit mask %b id %0d, required none (cycle %0d)",
                         simd_dispatch, dispatch_wave_id, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("dispatch mask %b id %0d cycle %0d (exp mask %b id %0d cycle %0d)",
                         simd_dispatch, dispatch_wave_id, cyc, e.mask, e.id, e.cyc);
                check("dispatch_mask", 32'(simd_dispatch), 32'(e.mask));
                check("dispatch_id", 32'(dispatch_wave_id), 32'(e.id));
                check("dispatch_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic push(input logic [3:0] m, input logic [7:0] id, input int c);
        exp_t e;
        e.mask = m;
        e.id   = id;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic launch_now(input logic [7:0] n);
        launch    = 1'b1;
        num_waves = n;
        @(posedge clk);
        #1;
        launch    = 1'b0;
    endtask

    task automatic done_at(input int c, input logic [3:0] m);
        wait_until(c);
        simd_wave_done = m;
        @(posedge clk);
        #1;
        simd_wave_done = 4'b0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        int kd0;
        rst            = 1'b1;
        launch         = 1'b0;
        num_waves      = 8'd0;
        simd_wave_done = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_dispatch", 32'(simd_dispatch), 32'd0);
        check("reset_id", 32'(dispatch_wave_id), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_kdone", 32'(kernel_done), 32'd0);
`ifdef WAVE_DISPATCH_PERF_EN
        check("reset_kcycles", kernel_cycles, 32'd0);
`endif

        // 1: four waves to four idle units, back to back.
        c0 = cyc; kd0 = kd_count;
        push(4'b0001, 8'd0, c0 + 2); push(4'b0010, 8'd1, c0 + 3);
        push(4'b0100, 8'd2, c0 + 4); push(4'b1000, 8'd3, c0 + 5);
        launch_now(8'd4);
        check("t1_busy_early", 32'(busy), 32'd1);
        wait_until(c0 + 6);
        check("t1_busy_drain", 32'(busy), 32'd1);
        done_at(c0 + 7, 4'b1111);
        wait_until(c0 + 9);
        check("t1_kdone", 32'(kernel_done), 32'd1);
        wait_until(c0 + 10);
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_kd_count", 32'(kd_count - kd0), 32'd1);
        check("t1_kd_cycle", 32'(kd_cyc), 32'(c0 + 9));
        check("t1_queue", 32'(exp_q.size()), 32'd0);

        // 2: six waves; waves 4 and 5 wait for frees and follow rr_ptr.
        c0 = cyc; kd0 = kd_count;
        push(4'b0001, 8'd0, c0 + 2); push(4'b0010, 8'd1, c0 + 3);
        push(4'b0100, 8'd2, c0 + 4); push(4'b1000, 8'd3, c0 + 5);
        push(4'b0100, 8'd4, c0 + 9); push(4'b1000, 8'd5, c0 + 12);
        launch_now(8'd6);
        done_at(c0 + 7, 4'b0100);
        done_at(c0 + 10, 4'b1001);
        done_at(c0 + 14, 4'b0010);
        done_at(c0 + 15, 4'b0100);
        done_at(c0 + 16, 4'b1000);
        check("t2_no_early_kdone", 32'(kernel_done), 32'd0);
        wait_until(c0 + 18);
        check("t2_kdone", 32'(kernel_done), 32'd1);
        check("t2_busy_done", 32'(busy), 32'd1);
        wait_until(c0 + 19);
        check("t2_busy_after", 32'(busy), 32'd0);
        check("t2_kd_count", 32'(kd_count - kd0), 32'd1);
        check("t2_queue", 32'(exp_q.size()), 32'd0);

        // 3: empty kernel.
        c0 = cyc; kd0 = kd_count;
        launch_now(8'd0);
        check("t3_kdone", 32'(kernel_done), 32'd1);
        check("t3_busy", 32'(busy), 32'd1);
        wait_until(c0 + 2);
        check("t3_busy_after", 32'(busy), 32'd0);
        check("t3_kdone_after", 32'(kernel_done), 32'd0);
        check("t3_kd_count", 32'(kd_count - kd0), 32'd1);

        // 4: done on idle units is ignored; a same-cycle free is not granted.
        c0 = cyc; kd0 = kd_count;
        push(4'b0001, 8'd0, c0 + 2); push(4'b0010, 8'd1, c0 + 3);
        push(4'b0100, 8'd2, c0 + 4); push(4'b1000, 8'd3, c0 + 5);
        push(4'b0100, 8'd4, c0 + 8); push(4'b0010, 8'd5, c0 + 9);
        launch_now(8'd6);
        done_at(c0 + 6, 4'b0100);
        done_at(c0 + 7, 4'b0110);
        done_at(c0 + 10, 4'b0001);
        done_at(c0 + 11, 4'b1000);
        done_at(c0 + 12, 4'b0100);
        done_at(c0 + 13, 4'b0001);
        wait_until(c0 + 15);
        check("t4_no_early_kdone", 32'(kernel_done), 32'd0);
        check("t4_no_early_count", 32'(kd_count - kd0), 32'd0);
        done_at(c0 + 15, 4'b0010);
        wait_until(c0 + 17);
        check("t4_kdone", 32'(kernel_done), 32'd1);
        wait_until(c0 + 18);
        check("t4_busy_after", 32'(busy), 32'd0);
        check("t4_kd_count", 32'(kd_count - kd0), 32'd1);
        check("t4_queue", 32'(exp_q.size()), 32'd0);

        // 5: second launch ignored, reset mid-dispatch, then a clean restart.
        c0 = cyc; kd0 = kd_count;
        push(4'b0100, 8'd0, c0 + 2); push(4'b1000, 8'd1, c0 + 3);
        launch_now(8'd6);
        wait_until(c0 + 2);
        launch_now(8'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_rst_dispatch", 32'(simd_dispatch), 32'd0);
        check("t5_rst_id", 32'(dispatch_wave_id), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_kdone", 32'(kernel_done), 32'd0);
`ifdef WAVE_DISPATCH_PERF_EN
        check("t5_rst_kcycles", kernel_cycles, 32'd0);
`endif
        check("t5_queue_mid", 32'(exp_q.size()), 32'd0);
        c1 = c0 + 5;
        wait_until(c1);
        push(4'b0001, 8'd0, c1 + 2); push(4'b0010, 8'd1, c1 + 3);
        launch_now(8'd2);
        done_at(c1 + 5, 4'b0011);
        wait_until(c1 + 7);
        check("t5_kdone", 32'(kernel_done), 32'd1);
        wait_until(c1 + 8);
        check("t5_busy_after", 32'(busy), 32'd0);
        check("t5_kd_count", 32'(kd_count - kd0), 32'd1);
        check("t5_queue", 32'(exp_q.size()), 32'd0);

`ifdef WAVE_DISPATCH_PERF_EN
        // 6: two waves each retired ten cycles after dispatch; 15 non-IDLE cycles.
        c0 = cyc;
        push(4'b0100, 8'd0, c0 + 2); push(4'b1000, 8'd1, c0 + 3);
        launch_now(8'd2);
        check("t6_kcycles_clear", kernel_cycles, 32'd0);
        done_at(c0 + 12, 4'b0100);
        done_at(c0 + 13, 4'b1000);
        wait_until(c0 + 15);
        check("t6_kdone", 32'(kernel_done), 32'd1);
        wait_until(c0 + 16);
        check("t6_kcycles", kernel_cycles, 32'd15);
        check("t6_busy_after", 32'(busy), 32'd0);
        wait_until(c0 + 20);
        check("t6_kcycles_hold", kernel_cycles, 32'd15);
        check("t6_queue", 32'(exp_q.size()), 32'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
